// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared defaults, clog2 helper and types for the LRU set array
package lru_pkg;

  localparam int DEFAULT_WAYS = 8;
  localparam int DEFAULT_SETS = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEFAULT_WAY_W = clog2(DEFAULT_WAYS);

  typedef logic [DEFAULT_WAY_W-1:0] age_t;
  typedef logic [DEFAULT_WAY_W-1:0] way_idx_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_ACK  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/lru_set_array_if.sv
// rtl/lru_set_array_if.sv - request/response bundle between a cache controller and the LRU array
interface lru_set_array_if import lru_pkg::*; #(
  parameter int WAYS = DEFAULT_WAYS,
  parameter int SETS = DEFAULT_SETS
);

  localparam int WAY_W = clog2(WAYS);
  localparam int SET_W = clog2(SETS);

  logic [SET_W-1:0]       i_set_idx;
  logic                   i_lru_write_enable;
  logic                   i_hit_sig;
  logic [WAYS-1:0]        i_hit_way;
  logic                   i_fill_req;
  logic [WAYS-1:0]        i_lock_mask;
  logic                   o_fill_ack;
  logic                   o_victim_valid;
  logic [WAY_W-1:0]       o_victim_way;
  logic                   o_err;
  logic [WAYS*WAY_W-1:0]  o_age_flat;

  modport master (
    output i_set_idx, i_lru_write_enable, i_hit_sig, i_hit_way, i_fill_req, i_lock_mask,
    input  o_fill_ack, o_victim_valid, o_victim_way, o_err, o_age_flat
  );

  modport slave (
    input  i_set_idx, i_lru_write_enable, i_hit_sig, i_hit_way, i_fill_req, i_lock_mask,
    output o_fill_ack, o_victim_valid, o_victim_way, o_err, o_age_flat
  );

endinterface

// File: rtl/lru_age_update.sv
// rtl/lru_age_update.sv - promotes one way of a set to MRU, ageing every younger way by one
module lru_age_update #(
  parameter int WAYS  = 8,
  parameter int WAY_W = 3
) (
  input  logic [WAYS*WAY_W-1:0] ages_in,
  input  logic [WAY_W-1:0]      promote,
  output logic [WAYS*WAY_W-1:0] ages_out
);

  logic [WAY_W-1:0] promote_age;
  logic [WAY_W-1:0] age;

  always_comb begin
    ages_out    = ages_in;
    promote_age = ages_in[int'(promote)*WAY_W +: WAY_W];
    age         = '0;
    for (int w = 0; w < WAYS; w++) begin
      age = ages_in[w*WAY_W +: WAY_W];
      // Ways older than the promoted one keep their age, preserving the permutation
      if (WAY_W'(w) == promote) begin
        ages_out[w*WAY_W +: WAY_W] = '0;
      end else if (age < promote_age) begin
        ages_out[w*WAY_W +: WAY_W] = age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lru_set_array.sv
// rtl/lru_set_array.sv - per-set true-LRU age array with hit promotion and locked-way victim fill
module lru_set_array import lru_pkg::*; #(
  parameter int WAYS = DEFAULT_WAYS,
  parameter int SETS = DEFAULT_SETS
) (
  input  logic           clk,
  input  logic           rst,
  lru_set_array_if.slave bus
);

  localparam int WAY_W  = clog2(WAYS);
  localparam int SET_W  = clog2(SETS);
  localparam int AGES_W = WAYS * WAY_W;

  function automatic logic [AGES_W-1:0] identity_ages();
    logic [AGES_W-1:0] r;
    r = '0;
    for (int w = 0; w < WAYS; w++) r[w*WAY_W +: WAY_W] = WAY_W'(w);
    return r;
  endfunction

  localparam logic [AGES_W-1:0] RESET_AGES = identity_ages();

  logic [AGES_W-1:0] age_mem [SETS];
  logic [SET_W-1:0]  set_idx;
  logic [AGES_W-1:0] cur_ages;
  logic [AGES_W-1:0] upd_ages;
  logic [AGES_W-1:0] next_ages;
  logic [WAY_W-1:0]  hit_idx;
  logic [WAY_W-1:0]  victim_idx;
  logic [WAY_W-1:0]  victim_age;
  logic [WAY_W-1:0]  promote_idx;
  logic              victim_found;
  logic              hit_onehot;
  logic              hit_ok;
  logic              hit_bad;
  logic              fill_accept;
  logic              do_update;

  fill_state_e       state_q;
  fill_state_e       state_d;
  logic              victim_valid_q;
  logic [WAY_W-1:0]  victim_way_q;
  logic              err_q;
  logic [AGES_W-1:0] age_flat_q;

  assign set_idx    = bus.i_set_idx;
  assign cur_ages   = age_mem[set_idx];
  assign hit_onehot = $onehot(bus.i_hit_way);
  assign hit_ok     = bus.i_lru_write_enable && bus.i_hit_sig && hit_onehot;
  assign hit_bad    = bus.i_lru_write_enable && bus.i_hit_sig && !hit_onehot;

  // A fill is refused while its own ack is showing, so a held request cannot double-fire
  assign fill_accept = bus.i_lru_write_enable && bus.i_fill_req && !bus.i_hit_sig
                       && (state_q == FILL_IDLE);

  always_comb begin
    hit_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.i_hit_way[w]) hit_idx = hit_idx | WAY_W'(w);
    end
  end

  always_comb begin
    victim_found = 1'b0;
    victim_idx   = '0;
    victim_age   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!bus.i_lock_mask[w] &&
          (!victim_found || (cur_ages[w*WAY_W +: WAY_W] > victim_age))) begin
        victim_found = 1'b1;
        victim_idx   = WAY_W'(w);
        victim_age   = cur_ages[w*WAY_W +: WAY_W];
      end
    end
  end

  assign promote_idx = hit_ok ? hit_idx : victim_idx;
  assign do_update   = hit_ok || (fill_accept && victim_found);

  lru_age_update #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_age_update (
    .ages_in  (cur_ages),
    .promote  (promote_idx),
    .ages_out (upd_ages)
  );

  assign next_ages = do_update ? upd_ages : cur_ages;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL_IDLE: if (fill_accept) state_d = FILL_ACK;
      FILL_ACK:  state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) age_mem[s] <= RESET_AGES;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      err_q          <= 1'b0;
      age_flat_q     <= RESET_AGES;
    end else begin
      if (do_update) age_mem[set_idx] <= next_ages;
      victim_valid_q <= fill_accept && victim_found;
      victim_way_q   <= (fill_accept && victim_found) ? victim_idx : '0;
      err_q          <= hit_bad;
      age_flat_q     <= next_ages;
    end
  end

  assign bus.o_fill_ack     = (state_q == FILL_ACK);
  assign bus.o_victim_valid = victim_valid_q;
  assign bus.o_victim_way   = victim_way_q;
  assign bus.o_err          = err_q;
  assign bus.o_age_flat     = age_flat_q;

endmodule

// File: tb/tb_lru_set_array.sv
// tb/tb_lru_set_array.sv - directed bench with a fill-result scoreboard for lru_set_array
module tb_lru_set_array;
  import lru_pkg::*;

  localparam int WAYS  = 8;
  localparam int SETS  = 16;
  localparam int WAY_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lru_set_array_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

  lru_set_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic             valid;
    logic [WAY_W-1:0] way;
  } fill_exp_t;

  fill_exp_t         exp_q [$];
  int                errors = 0;
  int                checks = 0;
  logic [23:0]       exp_set [SETS];

  function automatic logic [23:0] ages8(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7);
    logic [23:0] r;
    r = {age_t'(a7), age_t'(a6), age_t'(a5), age_t'(a4),
         age_t'(a3), age_t'(a2), age_t'(a1), age_t'(a0)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    fill_exp_t e;
    if (rst && bus.o_fill_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(bus.o_fill_ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("victim_valid", 32'(bus.o_victim_valid), 32'(e.valid));
        chk("victim_way", 32'(bus.o_victim_way), 32'(e.way));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_set_idx          = '0;
    bus.i_lru_write_enable = 1'b1;
    bus.i_hit_sig          = 1'b0;
    bus.i_hit_way          = '0;
    bus.i_fill_req         = 1'b0;
    bus.i_lock_mask        = '0;

    #12;
    chk("rst_ack", 32'(bus.o_fill_ack), 32'd0);
    chk("rst_vvalid", 32'(bus.o_victim_valid), 32'd0);
    chk("rst_vway", 32'(bus.o_victim_way), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_ages", 32'(bus.o_age_flat), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    @(negedge clk);
    rst = 1'b1;

    // set 0: hits then a free fill
    bus.i_hit_sig = 1'b1;
    bus.i_hit_way = 8'h20;
    tick();
    chk("hit5_ages", 32'(bus.o_age_flat), 32'(ages8(1, 2, 3, 4, 5, 0, 6, 7)));
    chk("hit5_err", 32'(bus.o_err), 32'd0);
    bus.i_hit_way = 8'h01;
    tick();
    chk("hit0_ages", 32'(bus.o_age_flat), 32'(ages8(0, 2, 3, 4, 5, 1, 6, 7)));
    tick();
    chk("hit_mru_ages", 32'(bus.o_age_flat), 32'(ages8(0, 2, 3, 4, 5, 1, 6, 7)));
    bus.i_hit_sig  = 1'b0;
    bus.i_hit_way  = '0;
    bus.i_fill_req = 1'b1;
    exp_q.push_back('{valid: 1'b1, way: 3'd7});
    tick();
    chk("fill0_ack", 32'(bus.o_fill_ack), 32'd1);
    chk("fill0_ages", 32'(bus.o_age_flat), 32'(ages8(1, 3, 4, 5, 6, 2, 7, 0)));
    bus.i_fill_req = 1'b0;
    tick();
    chk("fill0_ack_drop", 32'(bus.o_fill_ack), 32'd0);

    // set 3: all locked, then held request with only way 7 locked
    bus.i_set_idx   = 4'd3;
    bus.i_lock_mask = 8'hFF;
    bus.i_fill_req  = 1'b1;
    exp_q.push_back('{valid: 1'b0, way: 3'd0});
    tick();
    chk("lockall_ack", 32'(bus.o_fill_ack), 32'd1);
    chk("lockall_ages", 32'(bus.o_age_flat), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    tick();
    chk("held_no_reaccept", 32'(bus.o_fill_ack), 32'd0);
    bus.i_lock_mask = 8'h80;
    exp_q.push_back('{valid: 1'b1, way: 3'd6});
    tick();
    chk("lock7_ack", 32'(bus.o_fill_ack), 32'd1);
    chk("lock7_ages", 32'(bus.o_age_flat), 32'(ages8(1, 2, 3, 4, 5, 6, 0, 7)));
    bus.i_fill_req  = 1'b0;
    bus.i_lock_mask = '0;
    tick();

    // set 1: hit beats a same-cycle fill, fill lands next cycle
    bus.i_set_idx  = 4'd1;
    bus.i_hit_sig  = 1'b1;
    bus.i_hit_way  = 8'h04;
    bus.i_fill_req = 1'b1;
    tick();
    chk("hitfill_ack", 32'(bus.o_fill_ack), 32'd0);
    chk("hitfill_ages", 32'(bus.o_age_flat), 32'(ages8(1, 2, 0, 3, 4, 5, 6, 7)));
    bus.i_hit_sig = 1'b0;
    bus.i_hit_way = '0;
    exp_q.push_back('{valid: 1'b1, way: 3'd7});
    tick();
    chk("retry_ack", 32'(bus.o_fill_ack), 32'd1);
    chk("retry_ages", 32'(bus.o_age_flat), 32'(ages8(2, 3, 1, 4, 5, 6, 7, 0)));
    bus.i_fill_req = 1'b0;

    // illegal hit vectors
    bus.i_hit_sig = 1'b1;
    bus.i_hit_way = 8'h03;
    tick();
    chk("multihot_err", 32'(bus.o_err), 32'd1);
    chk("multihot_ages", 32'(bus.o_age_flat), 32'(ages8(2, 3, 1, 4, 5, 6, 7, 0)));
    bus.i_hit_way = 8'h00;
    tick();
    chk("zerohot_err", 32'(bus.o_err), 32'd1);
    bus.i_hit_sig = 1'b0;
    tick();
    chk("err_pulse_end", 32'(bus.o_err), 32'd0);

    // frozen: requests ignored, readback still follows the index
    for (int s = 0; s < SETS; s++) exp_set[s] = ages8(0, 1, 2, 3, 4, 5, 6, 7);
    exp_set[0] = ages8(1, 3, 4, 5, 6, 2, 7, 0);
    exp_set[1] = ages8(2, 3, 1, 4, 5, 6, 7, 0);
    exp_set[3] = ages8(1, 2, 3, 4, 5, 6, 0, 7);
    bus.i_lru_write_enable = 1'b0;
    bus.i_fill_req         = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.i_set_idx = 4'(i);
      bus.i_hit_sig = i[0];
      bus.i_hit_way = (i == 5) ? 8'h03 : 8'(1 << (i % 8));
      tick();
      chk("frozen_ack", 32'(bus.o_fill_ack), 32'd0);
      chk("frozen_err", 32'(bus.o_err), 32'd0);
      chk("frozen_ages", 32'(bus.o_age_flat), 32'(exp_set[i]));
    end
    bus.i_hit_sig          = 1'b0;
    bus.i_hit_way          = '0;
    bus.i_fill_req         = 1'b0;
    bus.i_lru_write_enable = 1'b1;
    tick();

    // reset while a fill ack is pending
    bus.i_set_idx  = 4'd1;
    bus.i_fill_req = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midfill_rst_ack", 32'(bus.o_fill_ack), 32'd0);
    chk("midfill_rst_ages", 32'(bus.o_age_flat), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    bus.i_fill_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_ack", 32'(bus.o_fill_ack), 32'd0);
    bus.i_lru_write_enable = 1'b0;
    bus.i_set_idx = 4'd0;
    tick();
    chk("post_rst_set0", 32'(bus.o_age_flat), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    bus.i_set_idx = 4'd1;
    tick();
    chk("post_rst_set1", 32'(bus.o_age_flat), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    bus.i_set_idx = 4'd3;
    tick();
    chk("post_rst_set3", 32'(bus.o_age_flat), 32'(ages8(0, 1, 2, 3, 4, 5, 6, 7)));
    chk("post_rst_ack2", 32'(bus.o_fill_ack), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lru_set_array.md
LRU_SET_ARRAY -- requirements
Module: lru_set_array

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning associativity (power of two, 2..16).
REQ-002 SHALL have parameter SETS, default 16, meaning number of independent LRU sets (power of two).
REQ-003 SHALL have localparams WAY_W = clog2(WAYS) and SET_W = clog2(SETS).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_set_idx  input  SET_W  set addressed this cycle.
REQ-007 i_lru_write_enable  input  1  global update enable; 0 freezes all state except outputs.
REQ-008 i_hit_sig  input  1  hit update request.
REQ-009 i_hit_way  input  WAYS  one-hot hit way.
REQ-010 i_fill_req  input  1  miss/victim request, level, held until ack.
REQ-011 i_lock_mask  input  WAYS  ways excluded from victim selection.
REQ-012 o_fill_ack  output  1  one-cycle pulse completing a fill.
REQ-013 o_victim_valid  output  1  qualifies o_victim_way when o_fill_ack=1.
REQ-014 o_victim_way  output  WAY_W  victim index.
REQ-015 o_err  output  1  one-cycle pulse: illegal i_hit_way.
REQ-016 o_age_flat  output  WAYS*WAY_W  registered ages of last addressed set, way0 in LSBs.

Function
REQ-017 Each set SHALL hold one WAY_W-bit age per way; ages of a set SHALL always be a permutation of 0..WAYS-1 (0 = MRU, WAYS-1 = LRU).
REQ-018 Hit: at edge with write_enable=1, hit_sig=1, hit_way exactly one-hot: hit way w (age a) -> 0; every way with age < a -> +1; others unchanged.
REQ-019 Hit to the current MRU way (a=0) SHALL leave the set unchanged.
REQ-020 hit_sig=1 with hit_way zero or multi-hot: no update, o_err=1 next cycle.
REQ-021 Fill accepted at edge with write_enable=1, fill_req=1, hit_sig=0, and o_fill_ack=0 in that cycle.
REQ-022 Victim = unlocked way with largest age in addressed set; on acceptance that way SHALL be promoted per REQ-018.
REQ-023 One cycle after acceptance: o_fill_ack=1, o_victim_valid=1, o_victim_way=victim (latency 1).
REQ-024 All ways locked: o_fill_ack=1, o_victim_valid=0, o_victim_way=0, set unchanged.
REQ-025 Hit and fill same cycle: hit SHALL win; fill not accepted and retried next cycle while held.
REQ-026 Back-to-back: requester SHALL drop fill_req in the ack cycle; a held request SHALL NOT be re-accepted in the ack cycle (max one fill per 2 cycles).
REQ-027 write_enable=0: no hit/fill acceptance, no o_err, ages frozen; o_age_flat still tracks i_set_idx.
REQ-028 o_age_flat SHALL register the post-update ages of i_set_idx each edge.
REQ-029 Lock mask SHALL NOT affect hit updates.

Reset
REQ-030 rst low SHALL asynchronously set age of way w = w in every set.
REQ-031 During reset: o_fill_ack=0, o_victim_valid=0, o_victim_way=0, o_err=0, o_age_flat = reset ages of set 0.
REQ-032 Reset mid-fill SHALL discard the pending ack; no state change after release until a new request.

Structure
REQ-033 A shared package lru_pkg SHALL hold default WAYS/SETS, clog2 helper, and age/way-index typedefs.
REQ-034 One sub-module lru_age_update SHALL compute next ages of one set from current ages and promoted-way index (combinational, shared by hit and fill paths).
REQ-035 Victim search SHALL be a masked max-age reduction within lru_set_array.

Verification (WAYS=8, SETS=16)
REQ-036 Reset, hit set0 way5 (0x20) -> set0 ages way0..7 = 1,2,3,4,5,0,6,7.
REQ-037 Then hit set0 way0 (0x01) -> ages 0,2,3,4,5,1,6,7; then fill set0, mask 0 -> ack next cycle, victim 7, ages 1,3,4,5,6,2,7,0.
REQ-038 Fresh set3, mask 0x80, fill -> victim 6; mask 0xFF -> ack, o_victim_valid=0, ages unchanged 0..7.
REQ-039 Same-cycle hit way2 + fill on set1 -> hit applied, ack only two cycles later with victim 7; i_hit_way=0x03 with hit_sig=1 -> o_err pulse, no change.
REQ-040 write_enable=0 with hits/fills for 10 cycles -> no acks, all ages unchanged; rst low during accepted fill -> no ack, ages back to 0..7.
